// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the reset sequencer: FSM state encoding,
// parameter defaults and the sizing rule for the shared cycle counter.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_WAIT_LOCK,
        ST_RELEASE,
        ST_RUN,
        ST_SW_GATE,
        ST_SW_HOLD
    } state_t;

    localparam int DEF_NB_DOMAINS  = 3;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_LOCK_TIMEOUT = 64;
    localparam int DEF_RELEASE_GAP = 4;
    localparam int DEF_HOLD_CYCLES = 8;

    // Width able to hold the largest terminal count of the three phases.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset-deassertion synchroniser: asserts asynchronously, releases after
// STAGES rising edges of clk_i.
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n,
    output logic rst_n_sync
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= STAGES'({sync_reg, 1'b1});
        end
    end

    assign rst_n_sync = sync_reg[STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Multi-domain reset sequencer: waits for FLL lock, releases domains one by
// one, and handles per-domain software resets with clock gating around them.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NB_DOMAINS   = DEF_NB_DOMAINS,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int RELEASE_GAP  = DEF_RELEASE_GAP,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  testmode_i,
    input  logic                  lock_i,
    input  logic [NB_DOMAINS-1:0] sw_req_i,
    input  logic                  fetch_enable_i,
    output logic [NB_DOMAINS-1:0] rstn_o,
    output logic [NB_DOMAINS-1:0] clk_en_o,
    output logic                  fetch_enable_o,
    output logic                  busy_o,
    output logic                  lock_timeout_o
);

    localparam int IDX_W = (NB_DOMAINS > 1) ? $clog2(NB_DOMAINS) : 1;
    localparam int CNT_W = cnt_width(LOCK_TIMEOUT - 1, RELEASE_GAP, HOLD_CYCLES - 1);

    state_t                state_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [NB_DOMAINS-1:0] sel_reg;
    logic [NB_DOMAINS-1:0] mask_reg;
    logic [NB_DOMAINS-1:0] rstn_reg;
    logic [NB_DOMAINS-1:0] clk_en_reg;
    logic                  fetch_reg;
    logic                  timeout_reg;
    logic                  rst_n_sync;
    logic [IDX_W:0]        next_pick;
    logic [IDX_W:0]        first_mask_pick;

    // Returns {found, index} of the lowest set bit of sel at or above 'from'.
    function automatic logic [IDX_W:0] pick_domain(input logic [NB_DOMAINS-1:0] sel,
                                                   input int from);
        logic [IDX_W:0] res;
        res = '0;
        for (int i = NB_DOMAINS - 1; i >= 0; i--) begin
            if (sel[i] && (i >= from)) res = {1'b1, IDX_W'(i)};
        end
        return res;
    endfunction

    rst_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .rst_n_sync (rst_n_sync)
    );

    assign next_pick       = pick_domain(sel_reg, int'(idx_reg) + 1);
    assign first_mask_pick = pick_domain(mask_reg, 0);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_RESET;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            sel_reg     <= '0;
            mask_reg    <= '0;
            rstn_reg    <= '0;
            clk_en_reg  <= '0;
            fetch_reg   <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            fetch_reg <= fetch_enable_i && (state_reg == ST_RUN);
            case (state_reg)
                ST_RESET: begin
                    if (rst_n_sync) begin
                        state_reg <= ST_WAIT_LOCK;
                        cnt_reg   <= '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_i || (cnt_reg == CNT_W'(LOCK_TIMEOUT - 1))) begin
                        if (!lock_i) timeout_reg <= 1'b1;
                        state_reg <= ST_RELEASE;
                        sel_reg   <= '1;
                        idx_reg   <= '0;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    // Each slot: clock on at count 0, reset off at count 1.
                    if (cnt_reg == CNT_W'(0)) clk_en_reg[idx_reg] <= 1'b1;
                    if (cnt_reg == CNT_W'(1)) rstn_reg[idx_reg] <= 1'b1;
                    if ((cnt_reg == CNT_W'(RELEASE_GAP - 1)) && next_pick[IDX_W]) begin
                        idx_reg <= next_pick[IDX_W-1:0];
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_W'(RELEASE_GAP)) begin
                        state_reg <= ST_RUN;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (|sw_req_i) begin
                        mask_reg   <= sw_req_i;
                        clk_en_reg <= clk_en_reg & ~sw_req_i;
                        state_reg  <= ST_SW_GATE;
                    end
                end
                ST_SW_GATE: begin
                    rstn_reg  <= rstn_reg & ~mask_reg;
                    cnt_reg   <= '0;
                    state_reg <= ST_SW_HOLD;
                end
                ST_SW_HOLD: begin
                    if (cnt_reg == CNT_W'(HOLD_CYCLES - 1)) begin
                        state_reg <= first_mask_pick[IDX_W] ? ST_RELEASE : ST_RUN;
                        sel_reg   <= mask_reg;
                        idx_reg   <= first_mask_pick[IDX_W-1:0];
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= ST_RESET;
            endcase
        end
    end

    // Test mode bypasses the sequencer so scan sees the raw reset and free clocks.
    for (genvar gi = 0; gi < NB_DOMAINS; gi++) begin : g_out
        assign rstn_o[gi]   = testmode_i ? rst_n : rstn_reg[gi];
        assign clk_en_o[gi] = testmode_i | clk_en_reg[gi];
    end

    assign fetch_enable_o = fetch_reg;
    assign busy_o         = (state_reg != ST_RUN);
    assign lock_timeout_o = timeout_reg;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with default parameters.
module tb_rst_seq_ctrl;

    logic       clk_i;
    logic       rst_n;
    logic       testmode_i;
    logic       lock_i;
    logic [2:0] sw_req_i;
    logic       fetch_enable_i;
    logic [2:0] rstn_o;
    logic [2:0] clk_en_o;
    logic       fetch_enable_o;
    logic       busy_o;
    logic       lock_timeout_o;

    int total = 0;
    int bad   = 0;

    // Power-up release, offsets N..N+12
    logic [2:0] pu_ce [0:12] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b011, 3'b011, 3'b011,
                                 3'b011, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
    logic [2:0] pu_rn [0:12] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b011, 3'b011,
                                 3'b011, 3'b011, 3'b111, 3'b111, 3'b111, 3'b111};
    logic       pu_by [0:12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};

    // Software reset of mask 3'b101, offsets from the request edge
    logic [2:0] sw_ce [0:18] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010,
                                 3'b010, 3'b010, 3'b010, 3'b011, 3'b011, 3'b011, 3'b011,
                                 3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
    logic [2:0] sw_rn [0:18] = '{3'b111, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010,
                                 3'b010, 3'b010, 3'b010, 3'b010, 3'b011, 3'b011, 3'b011,
                                 3'b011, 3'b111, 3'b111, 3'b111, 3'b111};
    logic       sw_by [0:18] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};

    rst_seq_ctrl dut (
        .clk_i          (clk_i),
        .rst_n          (rst_n),
        .testmode_i     (testmode_i),
        .lock_i         (lock_i),
        .sw_req_i       (sw_req_i),
        .fetch_enable_i (fetch_enable_i),
        .rstn_o         (rstn_o),
        .clk_en_o       (clk_en_o),
        .fetch_enable_o (fetch_enable_o),
        .busy_o         (busy_o),
        .lock_timeout_o (lock_timeout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic power_up(input logic lk);
        @(negedge clk_i);
        rst_n    = 1'b0;
        lock_i   = lk;
        sw_req_i = '0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rst_n = 1'b0;
        step(2);
        total++; if (rstn_o !== 3'b000) begin bad++; $display("FAIL reset_rstn: got %b want 000", rstn_o); end
        total++; if (clk_en_o !== 3'b000) begin bad++; $display("FAIL reset_clk_en: got %b want 000", clk_en_o); end
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", busy_o); end
        total++; if (fetch_enable_o !== 1'b0) begin bad++; $display("FAIL reset_fetch: got %b want 0", fetch_enable_o); end
        total++; if (lock_timeout_o !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", lock_timeout_o); end
        $display("reset: rstn=%b clk_en=%b busy=%b", rstn_o, clk_en_o, busy_o);
    endtask

    task automatic test_powerup_lock();
        power_up(1'b1);
        step(4);
        total++; if (clk_en_o !== 3'b000) begin bad++; $display("FAIL pu_early_clk_en: got %b want 000", clk_en_o); end
        for (int off = 0; off <= 12; off++) begin
            step(1);
            total++; if (clk_en_o !== pu_ce[off]) begin bad++; $display("FAIL pu_clk_en N+%0d: got %b want %b", off, clk_en_o, pu_ce[off]); end
            total++; if (rstn_o !== pu_rn[off]) begin bad++; $display("FAIL pu_rstn N+%0d: got %b want %b", off, rstn_o, pu_rn[off]); end
            total++; if (busy_o !== pu_by[off]) begin bad++; $display("FAIL pu_busy N+%0d: got %b want %b", off, busy_o, pu_by[off]); end
            $display("powerup N+%0d: clk_en=%b rstn=%b busy=%b", off, clk_en_o, rstn_o, busy_o);
        end
        total++; if (lock_timeout_o !== 1'b0) begin bad++; $display("FAIL pu_timeout: got %b want 0", lock_timeout_o); end
    endtask

    task automatic test_fetch();
        fetch_enable_i = 1'b1;
        total++; if (fetch_enable_o !== 1'b0) begin bad++; $display("FAIL fetch_latency: got %b want 0", fetch_enable_o); end
        step(1);
        total++; if (fetch_enable_o !== 1'b1) begin bad++; $display("FAIL fetch_on: got %b want 1", fetch_enable_o); end
        fetch_enable_i = 1'b0;
        step(1);
        total++; if (fetch_enable_o !== 1'b0) begin bad++; $display("FAIL fetch_off: got %b want 0", fetch_enable_o); end
        fetch_enable_i = 1'b1;
        step(1);
        $display("fetch: fetch_enable_o=%b", fetch_enable_o);
    endtask

    task automatic test_lock_loss();
        lock_i = 1'b0;
        step(5);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL lockloss_busy: got %b want 0", busy_o); end
        total++; if (rstn_o !== 3'b111) begin bad++; $display("FAIL lockloss_rstn: got %b want 111", rstn_o); end
        total++; if (clk_en_o !== 3'b111) begin bad++; $display("FAIL lockloss_clk_en: got %b want 111", clk_en_o); end
        lock_i = 1'b1;
        $display("lock loss: busy=%b rstn=%b", busy_o, rstn_o);
    endtask

    task automatic test_sw_reset();
        sw_req_i = 3'b101;
        for (int off = 0; off <= 18; off++) begin
            step(1);
            sw_req_i = 3'b000;
            total++; if (clk_en_o !== sw_ce[off]) begin bad++; $display("FAIL sw_clk_en +%0d: got %b want %b", off, clk_en_o, sw_ce[off]); end
            total++; if (rstn_o !== sw_rn[off]) begin bad++; $display("FAIL sw_rstn +%0d: got %b want %b", off, rstn_o, sw_rn[off]); end
            total++; if (busy_o !== sw_by[off]) begin bad++; $display("FAIL sw_busy +%0d: got %b want %b", off, busy_o, sw_by[off]); end
            if (off == 0) begin
                total++; if (fetch_enable_o !== 1'b1) begin bad++; $display("FAIL sw_fetch_run: got %b want 1", fetch_enable_o); end
            end
            if (off == 1) begin
                total++; if (fetch_enable_o !== 1'b0) begin bad++; $display("FAIL sw_fetch_gate: got %b want 0", fetch_enable_o); end
            end
            $display("sw 101 +%0d: clk_en=%b rstn=%b busy=%b", off, clk_en_o, rstn_o, busy_o);
        end
    endtask

    task automatic test_ignore_outside_run();
        sw_req_i = 3'b001;
        step(1);
        sw_req_i = 3'b000;
        step(9);
        sw_req_i = 3'b010;
        step(3);
        sw_req_i = 3'b000;
        step(2);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL ign_run: got %b want 0", busy_o); end
        step(3);
        total++; if (rstn_o !== 3'b111) begin bad++; $display("FAIL ign_rstn: got %b want 111", rstn_o); end
        total++; if (clk_en_o !== 3'b111) begin bad++; $display("FAIL ign_clk_en: got %b want 111", clk_en_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL ign_busy: got %b want 0", busy_o); end
        $display("ignore: rstn=%b clk_en=%b busy=%b", rstn_o, clk_en_o, busy_o);
    endtask

    task automatic test_timeout();
        power_up(1'b0);
        step(66);
        total++; if (lock_timeout_o !== 1'b0) begin bad++; $display("FAIL to_early: got %b want 0", lock_timeout_o); end
        step(1);
        total++; if (lock_timeout_o !== 1'b1) begin bad++; $display("FAIL to_flag: got %b want 1", lock_timeout_o); end
        step(1);
        total++; if (clk_en_o !== 3'b001) begin bad++; $display("FAIL to_clk_en0: got %b want 001", clk_en_o); end
        step(11);
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL to_busy_pre: got %b want 1", busy_o); end
        step(1);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL to_run: got %b want 0", busy_o); end
        total++; if (lock_timeout_o !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", lock_timeout_o); end
        lock_i = 1'b1;
        $display("timeout: lock_timeout=%b busy=%b", lock_timeout_o, busy_o);
    endtask

    task automatic test_reset_mid_hold();
        sw_req_i = 3'b100;
        step(1);
        sw_req_i = 3'b000;
        step(4);
        total++; if (rstn_o !== 3'b011) begin bad++; $display("FAIL hold_rstn: got %b want 011", rstn_o); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (rstn_o !== 3'b000) begin bad++; $display("FAIL mid_rstn: got %b want 000", rstn_o); end
        total++; if (clk_en_o !== 3'b000) begin bad++; $display("FAIL mid_clk_en: got %b want 000", clk_en_o); end
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy_o); end
        total++; if (fetch_enable_o !== 1'b0) begin bad++; $display("FAIL mid_fetch: got %b want 0", fetch_enable_o); end
        total++; if (lock_timeout_o !== 1'b0) begin bad++; $display("FAIL mid_timeout: got %b want 0", lock_timeout_o); end
        $display("mid-hold reset: rstn=%b clk_en=%b timeout=%b", rstn_o, clk_en_o, lock_timeout_o);
    endtask

    task automatic test_testmode();
        testmode_i = 1'b1;
        #1;
        total++; if (rstn_o !== 3'b000) begin bad++; $display("FAIL tm_rstn_low: got %b want 000", rstn_o); end
        total++; if (clk_en_o !== 3'b111) begin bad++; $display("FAIL tm_clk_en: got %b want 111", clk_en_o); end
        rst_n = 1'b1;
        #1;
        total++; if (rstn_o !== 3'b111) begin bad++; $display("FAIL tm_rstn_high: got %b want 111", rstn_o); end
        rst_n = 1'b0;
        #1;
        total++; if (rstn_o !== 3'b000) begin bad++; $display("FAIL tm_rstn_low2: got %b want 000", rstn_o); end
        rst_n = 1'b1;
        for (int i = 0; i < 40 && busy_o; i++) step(1);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL tm_fsm_run: got %b want 0", busy_o); end
        testmode_i = 1'b0;
        #1;
        total++; if (rstn_o !== 3'b111) begin bad++; $display("FAIL tm_exit_rstn: got %b want 111", rstn_o); end
        total++; if (clk_en_o !== 3'b111) begin bad++; $display("FAIL tm_exit_clk_en: got %b want 111", clk_en_o); end
        $display("testmode: rstn=%b clk_en=%b busy=%b", rstn_o, clk_en_o, busy_o);
    endtask

    initial begin
        rst_n          = 1'b1;
        testmode_i     = 1'b0;
        lock_i         = 1'b1;
        sw_req_i       = 3'b000;
        fetch_enable_i = 1'b0;
        test_reset();
        test_powerup_lock();
        test_fetch();
        test_lock_loss();
        test_sw_reset();
        test_ignore_outside_run();
        test_timeout();
        test_reset_mid_hold();
        test_testmode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 SHALL have parameter NB_DOMAINS, default 3, number of clock/reset domains sequenced.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, reset-deassertion synchroniser depth.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 64, max cycles waiting for FLL lock.
REQ-004 SHALL have parameter RELEASE_GAP, default 4 (min 2), cycles between successive domain releases.
REQ-005 SHALL have parameter HOLD_CYCLES, default 8, software-reset assertion length.
REQ-006 SHALL have port clk_i  in  1  single clock.
REQ-007 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port testmode_i  in  1  scan/test bypass.
REQ-009 SHALL have port lock_i  in  1  FLL lock, synchronous to clk_i.
REQ-010 SHALL have port sw_req_i  in  NB_DOMAINS  per-domain software reset request.
REQ-011 SHALL have port fetch_enable_i  in  1  core fetch enable request.
REQ-012 SHALL have port rstn_o  out  NB_DOMAINS  per-domain active-low reset.
REQ-013 SHALL have port clk_en_o  out  NB_DOMAINS  per-domain clock-gate enable.
REQ-014 SHALL have port fetch_enable_o  out  1  gated fetch enable.
REQ-015 SHALL have port busy_o  out  1  high whenever state is not RUN.
REQ-016 SHALL have port lock_timeout_o  out  1  sticky lock-timeout flag.

Function
REQ-017 FSM states SHALL be RESET, WAIT_LOCK, RELEASE, RUN, SW_GATE, SW_HOLD.
REQ-018 RESET SHALL go to WAIT_LOCK on the first cycle the synchronised reset is high (SYNC_STAGES edges after rst_n rises).
REQ-019 WAIT_LOCK SHALL go to RELEASE when lock_i=1, or after LOCK_TIMEOUT cycles, then setting lock_timeout_o=1 until rst_n.
REQ-020 RELEASE SHALL process selected domains in ascending index: clk_en_o[i] rises at cycle t, rstn_o[i] at t+1, next selected domain's clk_en_o at t+RELEASE_GAP.
REQ-021 RELEASE SHALL enter RUN RELEASE_GAP cycles after the last selected domain's clk_en_o rose; power-up selection is all domains.
REQ-022 In RUN, a nonzero sw_req_i SHALL be latched as mask and state SHALL go to SW_GATE.
REQ-023 SW_GATE SHALL clear clk_en_o[mask] for one cycle, then go to SW_HOLD with rstn_o[mask]=0.
REQ-024 SW_HOLD SHALL hold for HOLD_CYCLES cycles, then go to RELEASE with selection=mask.
REQ-025 Domains outside mask SHALL keep rstn_o and clk_en_o unchanged.
REQ-026 sw_req_i SHALL be ignored outside RUN (no queuing).
REQ-027 fetch_enable_o SHALL be registered fetch_enable_i AND (state==RUN), 1-cycle latency.
REQ-028 lock_i loss in RUN SHALL have no effect.
REQ-029 testmode_i=1 SHALL drive rstn_o to all copies of rst_n combinationally and clk_en_o to all ones; FSM keeps running.

Reset
REQ-030 rst_n low SHALL asynchronously force rstn_o=0, clk_en_o=0, fetch_enable_o=0, busy_o=1, lock_timeout_o=0, all counters 0, state RESET, in any state including mid-sequence.

Structure
REQ-031 Package rst_seq_pkg SHALL hold the state enum and parameter defaults.
REQ-032 Sub-module rst_sync (SYNC_STAGES flops, async clear) SHALL generate the synchronised reset.
REQ-033 A single counter SHALL be shared for timeout, gap and hold counting, sized for the largest parameter.

Verification (NB_DOMAINS=3, SYNC_STAGES=2, LOCK_TIMEOUT=64, RELEASE_GAP=4, HOLD_CYCLES=8)
REQ-034 Power-up, lock_i=1 -> clk_en_o[0] at N, rstn_o[0] at N+1, clk_en_o[1] at N+4, clk_en_o[2] at N+8, busy_o=0 at N+12.
REQ-035 lock_i=0 always -> lock_timeout_o=1 after 64 WAIT_LOCK cycles, release sequence proceeds.
REQ-036 RUN, sw_req_i=3'b101 -> clk_en_o[0],[2]=0 next cycle, rstn_o[0],[2]=0 one cycle later for 8 cycles, domain 1 untouched, domains 0 then 2 released 4 cycles apart.
REQ-037 sw_req_i=3'b010 during RELEASE -> no effect; rstn_o[1] stays 1 after RUN.
REQ-038 rst_n low mid SW_HOLD -> all outputs at reset values same cycle, no clock edge needed.
REQ-039 testmode_i=1, rst_n toggled -> rstn_o=3'b111/3'b000 follows rst_n combinationally, clk_en_o=3'b111.
